// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: bit-serial ALU sequencer wrapped around an external
// 1-bit result mux. Operands are shifted out LSB-first, the six per-bit
// candidates and the latched select go to the mux, and the mux output is
// shifted back into the result register (right shift, MSB entry).
// One operation takes WIDTH RUN cycles followed by a one-cycle DONE pulse.
// Optional feature macro: BSALU_FLAGS_EN adds carry_flag / zero_flag outputs.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       slct,
  output logic             mov_out,
  output logic             not_out,
  output logic             and_out,
  output logic             or_out,
  output logic             add_out,
  output logic             sub_out,
  input  logic             mux_in
`ifdef BSALU_FLAGS_EN
  ,
  output logic             carry_flag,
  output logic             zero_flag
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       slct_q, slct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q;
`ifdef BSALU_FLAGS_EN
  logic             carry_flag_q, carry_flag_d;
  logic             zero_flag_q, zero_flag_d;
`endif

  // Majority of three: carry-out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Next-state logic of the sequencer FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: operand latch/shift, carry chain, result assembly.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    slct_d   = slct_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
`ifdef BSALU_FLAGS_EN
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          slct_d  = opcode;
          cnt_d   = {CNT_W{1'b0}};
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          carry_d = (opcode == OP_SUB);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {mux_in, result_q[WIDTH-1:1]};
        if (slct_q == OP_ADD) begin
          carry_d = maj3(a_q[0], b_q[0], carry_q);
        end else if (slct_q == OP_SUB) begin
          carry_d = maj3(a_q[0], ~b_q[0], carry_q);
        end else begin
          carry_d = carry_q;
        end
        if (cnt_q == LAST_BIT) begin
          cnt_d = {CNT_W{1'b0}};
`ifdef BSALU_FLAGS_EN
          if ((slct_q == OP_ADD) || (slct_q == OP_SUB)) begin
            carry_flag_d = carry_d;
          end else begin
            carry_flag_d = 1'b0;
          end
          zero_flag_d = (result_d == {WIDTH{1'b0}});
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      slct_q   <= 3'b000;
      cnt_q    <= {CNT_W{1'b0}};
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BSALU_FLAGS_EN
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      slct_q   <= slct_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
`ifdef BSALU_FLAGS_EN
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
`endif
    end
  end

  // Per-bit candidates must reach the mux in the same cycle, so they are
  // decoded from the operand/carry registers and gated to zero outside RUN.
  always_comb begin
    mov_out = busy_q & a_q[0];
    not_out = busy_q & ~a_q[0];
    and_out = busy_q & (a_q[0] & b_q[0]);
    or_out  = busy_q & (a_q[0] | b_q[0]);
    add_out = busy_q & (a_q[0] ^ b_q[0] ^ carry_q);
    sub_out = busy_q & (a_q[0] ^ ~b_q[0] ^ carry_q);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign slct   = slct_q;
`ifdef BSALU_FLAGS_EN
  assign carry_flag = carry_flag_q;
  assign zero_flag  = zero_flag_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Testbench for bit_serial_alu_seq with the 1-bit ALU result mux modelled in
// the loop. A word-level reference (plain arithmetic on whole operands) gives
// the expected outputs every cycle; directed cases pin known values.
module tb_bit_serial_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [2:0]   slct;
  logic         mov_out, not_out, and_out, or_out, add_out, sub_out;
  logic         mux_in;
`ifdef BSALU_FLAGS_EN
  logic         carry_flag, zero_flag;
`endif

  int checks = 0;
  int failures = 0;
  bit sim_done = 1'b0;

  // Reference model state
  int           m_t = -1;
  logic [W-1:0] m_a = '0, m_b = '0, m_exp = '0, m_old = '0, m_res = '0;
  logic [2:0]   m_op = 3'b000;
  logic         m_cf = 1'b0, m_zf = 1'b0;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .slct(slct), .mov_out(mov_out), .not_out(not_out), .and_out(and_out),
    .or_out(or_out), .add_out(add_out), .sub_out(sub_out), .mux_in(mux_in)
`ifdef BSALU_FLAGS_EN
    , .carry_flag(carry_flag), .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // ALU result mux in the loop
  always_comb begin
    case (slct)
      3'b000:  mux_in = mov_out;
      3'b001:  mux_in = not_out;
      3'b011:  mux_in = and_out;
      3'b100:  mux_in = or_out;
      3'b101:  mux_in = sub_out;
      3'b110:  mux_in = add_out;
      default: mux_in = 1'b0;
    endcase
  end

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return ~a;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a - b;
      3'b110:  return a + b;
      default: return '0;
    endcase
  endfunction

  // Carry into bit i (i == W gives the final carry) of the op's adder chain.
  function automatic logic ref_cin(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    logic [W-1:0] nb;
    longint unsigned m, s;
    nb = ~b;
    m = (64'd1 << i) - 64'd1;
    if (op == 3'b110) s = (64'(a) & m) + (64'(b) & m);
    else if (op == 3'b101) s = (64'(a) & m) + (64'(nb) & m) + 64'd1;
    else s = 64'd0;
    return 1'((s >> i) & 64'd1);
  endfunction

  // Result after k bits of the new value have shifted in over the old one.
  function automatic logic [W-1:0] partial(input logic [W-1:0] old, input logic [W-1:0] nw, input int k);
    logic [2*W-1:0] cat;
    cat = {nw, old};
    return W'(cat >> k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each clock edge, resets asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = -1; m_res = '0; m_op = 3'b000; m_cf = 1'b0; m_zf = 1'b0;
        m_a = '0; m_b = '0;
      end else if (m_t < 0) begin
        if (start) begin
          m_a = op_a; m_b = op_b; m_op = opcode;
          m_exp = ref_op(opcode, op_a, op_b);
          m_old = m_res;
          m_t = 0;
        end
      end else begin
        m_t++;
        if (m_t <= W) m_res = partial(m_old, m_exp, m_t);
        if (m_t == W) begin
          m_cf = ((m_op == 3'b110) || (m_op == 3'b101)) ? ref_cin(m_op, m_a, m_b, W) : 1'b0;
          m_zf = (m_exp == '0);
        end
        if (m_t > W) m_t = -1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!sim_done) begin
        logic run, ai, bi, c;
        run = (m_t >= 0) && (m_t < W);
        ai = run ? m_a[m_t] : 1'b0;
        bi = run ? m_b[m_t] : 1'b0;
        c  = run ? ref_cin(m_op, m_a, m_b, m_t) : 1'b0;
        chk("busy", busy, run);
        chk("done", done, m_t == W);
        chk("result", result, m_res);
        chk("slct", slct, m_op);
        chk("mov_out", mov_out, ai);
        chk("not_out", not_out, run & ~ai);
        chk("and_out", and_out, ai & bi);
        chk("or_out", or_out, ai | bi);
        chk("add_out", add_out, run & (ai ^ bi ^ c));
        chk("sub_out", sub_out, run & (ai ^ ~bi ^ c));
`ifdef BSALU_FLAGS_EN
        chk("carry_flag", carry_flag, m_cf);
        chk("zero_flag", zero_flag, m_zf);
`endif
      end
    end
  end

  // Issue one operation from IDLE and wait (bounded) for done.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    @(posedge clk); #2;
    start = 1'b1; opcode = op; op_a = a; op_b = b;
    @(posedge clk); #2;
    start = 1'b0;
    for (n = 0; n < 4 * W; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_latency"}, n, W);
    chk(name, result, exp);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", result, 8'h00);
    chk("reset_busy", busy, 1'b0);

    // Hand-computed values pinning the reference model
    chk("ref_add", ref_op(3'b110, 8'h3C, 8'h05), 8'h41);
    chk("ref_sub", ref_op(3'b101, 8'h05, 8'h06), 8'hFF);
    chk("ref_sub_cout", ref_cin(3'b101, 8'h06, 8'h06, W), 1'b1);
    chk("ref_add_cout", ref_cin(3'b110, 8'hFF, 8'h01, W), 1'b1);

    run_op("add_3c_05", 3'b110, 8'h3C, 8'h05, 8'h41);
`ifdef BSALU_FLAGS_EN
    chk("add_3c_05_cf", carry_flag, 1'b0);
`endif
    run_op("sub_05_06", 3'b101, 8'h05, 8'h06, 8'hFF);
`ifdef BSALU_FLAGS_EN
    chk("sub_05_06_cf", carry_flag, 1'b0);
`endif
    run_op("sub_06_06", 3'b101, 8'h06, 8'h06, 8'h00);
`ifdef BSALU_FLAGS_EN
    chk("sub_06_06_zf", zero_flag, 1'b1);
    chk("sub_06_06_cf", carry_flag, 1'b1);
`endif
    run_op("not_a5", 3'b001, 8'hA5, 8'h00, 8'h5A);
    run_op("and_f0_3c", 3'b011, 8'hF0, 8'h3C, 8'h30);
    run_op("or_f0_3c", 3'b100, 8'hF0, 8'h3C, 8'hFC);
    run_op("mov_81", 3'b000, 8'h81, 8'h00, 8'h81);
    run_op("op010_ff", 3'b010, 8'hFF, 8'hFF, 8'h00);

    // start re-pulsed during RUN and DONE must be ignored
    @(posedge clk); #2;
    start = 1'b1; opcode = 3'b110; op_a = 8'hFF; op_b = 8'h01;
    @(posedge clk); #2; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; opcode = 3'b100; op_a = 8'h12; op_b = 8'h34;
    @(posedge clk); #2; start = 1'b0;
    begin
      int n;
      for (n = 0; n < 4 * W; n++) begin
        @(negedge clk);
        if (done) break;
      end
      chk("repulse_done_seen", done, 1'b1);
      chk("repulse_result", result, 8'h00);
`ifdef BSALU_FLAGS_EN
      chk("repulse_cf", carry_flag, 1'b1);
`endif
      #3 start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", busy, 1'b0);
    end

    // Reset in the middle of RUN aborts with no done pulse
    @(posedge clk); #2;
    start = 1'b1; opcode = 3'b110; op_a = 8'h77; op_b = 8'h11;
    @(posedge clk); #2; start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 8'h00);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    run_op("after_abort_add", 3'b110, 8'h3C, 8'h05, 8'h41);

    // Randomized traffic, including stray starts and occasional resets
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #2;
      rst_n  = ($urandom_range(0, 299) != 0);
      start  = ($urandom_range(0, 2) == 0);
      opcode = 3'($urandom);
      op_a   = W'($urandom);
      op_b   = W'($urandom);
    end
    @(posedge clk); #2;
    rst_n = 1'b1; start = 1'b0;
    repeat (W + 3) @(negedge clk);

    sim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
